// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing constants and coordinate type shared with renderers
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int PIPE_DEPTH_DEF = 1;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster coordinate and sync bundle driven by vga_timing_gen
interface vga_timing_gen_if;
    import vga_pkg::*;

    coord_t DrawX;
    coord_t DrawY;
    logic   blank;
    logic   hs;
    logic   vs;
    logic   frame_start;

    modport master (output DrawX, DrawY, blank, hs, vs, frame_start);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrap counter plus active/sync decode of its next value
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    output coord_t cnt_o,
    output logic   wrap_o,
    output logic   active_d_o,
    output logic   sync_n_d_o
);

    localparam int     TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam coord_t CNT_LAST   = coord_t'(TOTAL - 1);
    localparam coord_t ACTIVE_END = coord_t'(ACTIVE);
    localparam coord_t SYNC_FIRST = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_LAST  = coord_t'(ACTIVE + FP + SYNC - 1);

    if (TOTAL > COORD_MAX) begin : g_bad_total
        $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, COORD_MAX);
    end

    coord_t cnt_q;
    coord_t cnt_d;

    // Wrap is an explicit compare so totals below 1024 never rely on overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign wrap_o     = en_i && (cnt_q == CNT_LAST);
    assign active_d_o = (cnt_d < ACTIVE_END);
    assign sync_n_d_o = !((cnt_d >= SYNC_FIRST) && (cnt_d <= SYNC_LAST));

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_SYNC_DELAY_EN adds PIPE_DEPTH stages on syncs
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    vga_timing_gen_if.master        vga_o
);

    if (PIPE_DEPTH < 1) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE_DEPTH must be at least 1");
    end

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_active_d;
    logic   v_active_d;
    logic   h_sync_n_d;
    logic   v_sync_n_d;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en_i       (1'b1),
        .cnt_o      (h_cnt),
        .wrap_o     (h_wrap),
        .active_d_o (h_active_d),
        .sync_n_d_o (h_sync_n_d)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en_i       (h_wrap),
        .cnt_o      (v_cnt),
        .wrap_o     (v_wrap),
        .active_d_o (v_active_d),
        .sync_n_d_o (v_sync_n_d)
    );

    logic blank_q, blank_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic frame_start_q, frame_start_d;

    // Decoding the next counter values keeps these flops in step with DrawX/DrawY.
    always_comb begin
        blank_d       = h_active_d && v_active_d;
        hs_d          = h_sync_n_d;
        vs_d          = v_sync_n_d;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q       <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [PIPE_DEPTH-1:0] blank_pipe_q;
    logic [PIPE_DEPTH-1:0] hs_pipe_q;
    logic [PIPE_DEPTH-1:0] vs_pipe_q;
    logic [PIPE_DEPTH-1:0] fs_pipe_q;

    // Only the sync/blank side is delayed; renderers still address ROMs with undelayed DrawX/DrawY.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_pipe_q <= '0;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
            fs_pipe_q    <= '0;
        end else begin
            blank_pipe_q[0] <= blank_q;
            hs_pipe_q[0]    <= hs_q;
            vs_pipe_q[0]    <= vs_q;
            fs_pipe_q[0]    <= frame_start_q;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                blank_pipe_q[i] <= blank_pipe_q[i-1];
                hs_pipe_q[i]    <= hs_pipe_q[i-1];
                vs_pipe_q[i]    <= vs_pipe_q[i-1];
                fs_pipe_q[i]    <= fs_pipe_q[i-1];
            end
        end
    end

    assign vga_o.blank       = blank_pipe_q[PIPE_DEPTH-1];
    assign vga_o.hs          = hs_pipe_q[PIPE_DEPTH-1];
    assign vga_o.vs          = vs_pipe_q[PIPE_DEPTH-1];
    assign vga_o.frame_start = fs_pipe_q[PIPE_DEPTH-1];
`else
    assign vga_o.blank       = blank_q;
    assign vga_o.hs          = hs_q;
    assign vga_o.vs          = vs_q;
    assign vga_o.frame_start = frame_start_q;
`endif

    assign vga_o.DrawX = h_cnt;
    assign vga_o.DrawY = v_cnt;

endmodule
